// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared constants for the instruction-memory loader:
//     - instruction-memory geometry (depth / word-address width)
//     - length-field width of the load frame
//     - loader FSM state encoding
//     - checksum accumulation rule
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = 10;

    // Word count carried by the two length bytes of a frame.
    localparam int LEN_W = 16;

    // Loader FSM encoding.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    // Checksum is a plain running XOR over the data bytes only.
    function automatic logic [7:0] csum_xor(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_byte_packer
//   Packs an MSB-first byte stream into 32-bit words. Each shifted byte
//   enters at the bottom; after the fourth byte the assembled word is held
//   on o_word and o_word_valid pulses for exactly one cycle.
//
// Ports
//   i_clk         clock
//   i_rst_n       asynchronous active-low reset
//   i_clear       synchronous clear of the word, byte count and pulse
//   i_shift       accept i_byte this cycle
//   i_byte        incoming byte
//   o_word        packed word (stable in the o_word_valid cycle)
//   o_word_valid  one-cycle pulse: o_word holds a complete word
// ---------------------------------------------------------------------------
module imem_loader_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;
    logic        r_word_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word       <= '0;
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_word       <= '0;
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            // The pulse follows the edge that took the 4th byte. A byte
            // shifted during the pulse cycle lands only at the following
            // edge, so the completed word is intact while it is written.
            r_word_valid <= i_shift && (r_cnt == 2'd3);
            if (i_shift) begin
                r_word <= {r_word[23:0], i_byte};
                r_cnt  <= r_cnt + 2'd1;
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Receives a framed program image
//   over a valid/ready byte stream, packs it into 32-bit words, writes them
//   to instruction memory and holds the core halted until the image has been
//   received with a matching checksum.
//
//   Frame: LEN_HI, LEN_LO (word count N, big-endian), 4*N data bytes (each
//   word MSB first), one checksum byte = XOR of the data bytes.
//
// Ports
//   i_clk         clock (posedge)
//   i_rst_n       asynchronous active-low reset
//   i_load_req    one-cycle pulse: halt core, start a load (ignored while busy)
//   i_rx_data     stream byte
//   i_rx_valid    stream byte valid
//   o_rx_ready    loader accepts a byte (transfer = valid & ready)
//   o_imem_we     instruction-memory write strobe, one cycle per word
//   o_imem_addr   word address of the write
//   o_imem_wdata  word written
//   o_core_run    1 = core executes, 0 = core held
//   o_busy        load in progress
//   o_load_err    bad length or checksum; held until the next load_req
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_req,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_run,
    output logic              o_busy,
    output logic              o_load_err
);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_word_idx;
    logic [7:0]        r_xor;

    logic              w_xfer;
    logic              w_start;
    logic              w_idle_like;
    logic [LEN_W-1:0]  w_len_n;
    logic              w_last_word;
    logic              w_pk_shift;
    logic [31:0]       w_pk_word;
    logic              w_pk_valid;

    // ---------------------------------------------------------------
    // Handshake / decode helpers
    // ---------------------------------------------------------------
    assign w_xfer      = i_rx_valid && o_rx_ready;
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_start     = w_idle_like && i_load_req;

    // Full word count as seen while the low length byte is on the bus.
    assign w_len_n     = {r_len[LEN_W-1:8], i_rx_data};

    // N >= 1 in DATA, and N <= DEPTH keeps N-1 within the index range.
    assign w_last_word = (LEN_W'(r_word_idx) == (r_len - LEN_W'(1)));

    assign w_pk_shift  = (r_state == S_DATA) && w_xfer;

    // ---------------------------------------------------------------
    // Byte packer
    // ---------------------------------------------------------------
    imem_loader_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_start),
        .i_shift      (w_pk_shift),
        .i_byte       (i_rx_data),
        .o_word       (w_pk_word),
        .o_word_valid (w_pk_valid)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_load_req) begin
                    w_next_state = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    w_next_state = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_n == '0) begin
                        w_next_state = S_CSUM;
                    end else if (w_len_n > LEN_W'(DEPTH)) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Leave only once the last word has actually been written.
                if (w_pk_valid && w_last_word) begin
                    w_next_state = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    w_next_state = (i_rx_data == r_xor) ? S_DONE : S_ERR;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        o_rx_ready = 1'b0;
        o_imem_we  = 1'b0;
        o_busy     = 1'b0;
        o_core_run = 1'b0;
        o_load_err = 1'b0;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_CSUM: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
            end
            S_DATA: begin
                o_busy    = 1'b1;
                o_imem_we = w_pk_valid;
                // Stall during the last word's write: the next byte is the
                // checksum and must be taken in CSUM, not shifted as data.
                o_rx_ready = !(w_pk_valid && w_last_word);
            end
            S_DONE:  o_core_run = 1'b1;
            S_ERR:   o_load_err = 1'b1;
            default: ;
        endcase
    end

    assign o_imem_addr  = r_word_idx;
    assign o_imem_wdata = w_pk_word;

    // ---------------------------------------------------------------
    // Length, word index and checksum registers
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_xor      <= '0;
        end else if (w_start) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_xor      <= '0;
        end else begin
            if ((r_state == S_LEN_HI) && w_xfer) begin
                r_len[LEN_W-1:8] <= i_rx_data;
            end
            if ((r_state == S_LEN_LO) && w_xfer) begin
                r_len[7:0] <= i_rx_data;
            end
            if (w_pk_shift) begin
                r_xor <= csum_xor(r_xor, i_rx_data);
            end
            // Hold the index on the last word so it never wraps past DEPTH-1.
            if (o_imem_we && !w_last_word) begin
                r_word_idx <= r_word_idx + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Scoreboarded bench for imem_loader. The stimulus side pushes each
//   expected instruction-memory write into exp_q; an independent monitor
//   pops and compares on every imem_we. Status outputs are checked directly
//   at the points where the frame protocol fixes their values.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_run;
    logic        busy;
    logic        load_err;

    imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load_req   (load_req),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_core_run   (core_run),
        .o_busy       (busy),
        .o_load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                chk("wr_data", imem_wdata, mon_e.data);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit jit);
        int  guard;
        bit  acc;
        if (jit) begin
            repeat ($urandom_range(0, 3)) begin
                rx_valid = 1'b0;
                tick();
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        do begin
            acc = rx_ready;
            tick();
            guard++;
        end while (!acc && guard < 100);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_timeout: got no accept for 0x%0h expected accept", b);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input bit jit);
        foreach (q[i]) send_byte(q[i], jit);
    endtask

    task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] w;
    logic [7:0]  cs;

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk1("rst_core_run", core_run, 1'b0);
        chk1("rst_busy",     busy,     1'b0);
        chk1("rst_rx_ready", rx_ready, 1'b0);
        chk1("rst_we",       imem_we,  1'b0);
        chk1("rst_load_err", load_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // ---------------- 1: reset mid-DATA ----------------
        push_wr(10'd0, 32'h11223344);
        pulse_load();
        chk1("t1_busy", busy, 1'b1);
        send_bytes('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB}, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("t1_rst_busy", busy, 1'b0);
        chk1("t1_rst_we",   imem_we, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk1("t1_core_run", core_run, 1'b0);
        chk1("t1_busy_idle", busy, 1'b0);
        chk1("t1_rdy_idle", rx_ready, 1'b0);
        // A byte offered in IDLE is ignored; the monitor flags any write.
        rx_data  = 8'hCC;
        rx_valid = 1'b1;
        repeat (10) tick();
        rx_valid = 1'b0;
        chk("t1_no_writes", 32'(exp_q.size()), 32'd0);

        // ---------------- 2: two-word load ----------------
        // XOR of 11 22 33 44 AA BB CC DD = 0x44.
        push_wr(10'd0, 32'h11223344);
        push_wr(10'd1, 32'hAABBCCDD);
        pulse_load();
        send_bytes('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                     8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0);
        // Last word's write cycle: stream must be stalled.
        chk1("t2_we_last",  imem_we,  1'b1);
        chk1("t2_rdy_last", rx_ready, 1'b0);
        send_byte(8'h44, 1'b0);
        chk1("t2_core_run", core_run, 1'b1);
        chk1("t2_busy",     busy,     1'b0);
        chk1("t2_load_err", load_err, 1'b0);

        // ---------------- 3: zero-length frames ----------------
        pulse_load();
        chk1("t3_run_drop", core_run, 1'b0);
        send_bytes('{8'h00, 8'h00, 8'h00}, 1'b0);
        chk1("t3a_core_run", core_run, 1'b1);
        pulse_load();
        send_bytes('{8'h00, 8'h00, 8'h01}, 1'b0);
        chk1("t3b_load_err", load_err, 1'b1);
        chk1("t3b_core_run", core_run, 1'b0);

        // ---------------- 4: length DEPTH+1 ----------------
        pulse_load();
        chk1("t4_err_clr", load_err, 1'b0);
        send_bytes('{8'h04, 8'h01}, 1'b0);
        chk1("t4_load_err", load_err, 1'b1);
        chk1("t4_rdy",      rx_ready, 1'b0);
        chk1("t4_busy",     busy,     1'b0);
        repeat (3) tick();
        chk1("t4_err_sticky", load_err, 1'b1);

        // ---------------- 4b: length exactly DEPTH ----------------
        pulse_load();
        send_bytes('{8'h04, 8'h00}, 1'b0);
        cs = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            w = {16'(i), 16'(~i)};
            push_wr(10'(i), w);
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            send_byte(w[31:24], 1'b0);
            send_byte(w[23:16], 1'b0);
            send_byte(w[15:8],  1'b0);
            send_byte(w[7:0],   1'b0);
        end
        send_byte(cs, 1'b0);
        chk1("t4b_core_run", core_run, 1'b1);

        // ---------------- 5: jittered stream + load_req mid-DATA --------
        push_wr(10'd0, 32'h11223344);
        push_wr(10'd1, 32'hAABBCCDD);
        pulse_load();
        send_bytes('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA}, 1'b1);
        pulse_load();
        chk1("t5_busy_kept", busy, 1'b1);
        send_bytes('{8'hBB, 8'hCC, 8'hDD, 8'h44}, 1'b1);
        chk1("t5_core_run", core_run, 1'b1);
        chk1("t5_load_err", load_err, 1'b0);

        // ---------------- 6: reload from DONE ----------------
        // XOR of DE AD BE EF = 0x22.
        push_wr(10'd0, 32'hDEADBEEF);
        pulse_load();
        chk1("t6_run_drop", core_run, 1'b0);
        send_bytes('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 1'b0);
        chk1("t6_core_run", core_run, 1'b1);

        repeat (5) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
